dct_mac_seq: RTL and testbench

DCT_MAC_SEQ -- requirements
Module: dct_mac_seq

---
 rtl/dct_mac_seq.sv | 125 ++++++++++++
 tb/tb_dct_mac_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dct_mac_seq.sv
// dct_mac_seq: eight-term signed multiply-accumulate for DCT rows.
//
// Pairs (din, coef) are accepted with a valid/ready handshake. Every eight
// accepted pairs form one block. The block's sum of products is presented on
// result with out_valid, and it is held until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   dclr       synchronous abort of the block in progress
//   in_valid   din/coef pair presented
//   in_ready   pair is accepted this cycle when in_valid is also high
//   din        signed sample, DWIDTH bits
//   coef       signed coefficient, CWIDTH bits
//   out_valid  result holds a completed 8-term sum
//   out_ready  consumer takes the result this cycle
//   result     signed sum of 8 products, RWIDTH bits
//
// The pipeline has two register stages: a product register (p1) and the
// accumulator/result register. A pair presented in cycle c therefore produces
// its result, visible to the consumer, in cycle c+2.
module dct_mac_seq #(
  parameter  int DWIDTH = 8,
  parameter  int CWIDTH = 12,
  localparam int RWIDTH = DWIDTH + CWIDTH + 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dclr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DWIDTH-1:0] din,
  input  logic signed [CWIDTH-1:0] coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [RWIDTH-1:0] result
);

  localparam int PWIDTH = DWIDTH + CWIDTH;

  logic [2:0]               cnt;
  logic signed [PWIDTH-1:0] p1;
  logic                     p1_vld;
  logic                     p1_last;
  logic signed [RWIDTH-1:0] acc;
  logic                     acc_empty;
  logic signed [RWIDTH-1:0] p1_ext;
  logic signed [RWIDTH-1:0] sum_next;
  logic                     accept;

  // Input stalls only while a finished result is waiting to be taken. A new
  // last product cannot arrive during a stall, because a full block of fresh
  // accepts is needed first. For this reason the held result is never
  // overwritten.
  assign in_ready = ~(out_valid & ~out_ready);
  assign accept   = in_valid & in_ready;

  // Stage-2 adder input. The product is sign-extended to the result width.
  // The first product of a block replaces the accumulator instead of being
  // added to it.
  always_comb begin
    p1_ext   = {{(RWIDTH - PWIDTH){p1[PWIDTH-1]}}, p1};
    sum_next = acc_empty ? p1_ext : acc + p1_ext;
  end

  // Stage 1: register the product of every accepted pair.
  // The pair taken at cnt == 7 is tagged as the last pair of its block.
  // An abort drops any pair accepted in the same cycle and restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      p1      <= '0;
      p1_vld  <= 1'b0;
      p1_last <= 1'b0;
    end else if (dclr) begin
      cnt     <= '0;
      p1_vld  <= 1'b0;
      p1_last <= 1'b0;
    end else if (accept) begin
      p1      <= din * coef;
      p1_vld  <= 1'b1;
      p1_last <= (cnt == 3'd7);
      cnt     <= cnt + 3'd1;
    end else begin
      p1_vld  <= 1'b0;
      p1_last <= 1'b0;
    end
  end

  // Stage 2: accumulate the products.
  // When the last product arrives, the final sum goes to result and the
  // accumulator is rearmed for the next block.
  // The out_valid update is independent of the abort. A handshake still
  // retires the held result, and a new last product has priority over the
  // handshake clear. This keeps back-to-back blocks free of bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      acc_empty <= 1'b1;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (dclr) begin
        acc       <= '0;
        acc_empty <= 1'b1;
      end else if (p1_vld) begin
        if (p1_last) begin
          result    <= sum_next;
          acc       <= '0;
          acc_empty <= 1'b1;
        end else begin
          acc       <= sum_next;
          acc_empty <= 1'b0;
        end
      end

      if (!dclr && p1_vld && p1_last) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct_mac_seq.sv
// tb_dct_mac_seq: self-checking bench for dct_mac_seq.
//
// The block model keeps a list of the accepted products. When the list
// reaches eight entries, the model computes their sum. That sum appears on
// the outputs one edge after the edge on which the last pair is accepted.
// A compare process checks the DUT against this model every cycle. The
// directed sections also check hand-computed literal sums.
module tb_dct_mac_seq;

  localparam int DW = 8;
  localparam int CW = 12;
  localparam int RW = DW + CW + 3;

  logic                 clk       = 1'b0;
  logic                 rst       = 1'b0;
  logic                 dclr      = 1'b0;
  logic                 in_valid  = 1'b0;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] din       = '0;
  logic signed [CW-1:0] coef      = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic signed [RW-1:0] result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dct_mac_seq #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .dclr      (dclr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .coef      (coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  // Block-level model state.
  bit exp_ov     = 1'b0;
  int exp_res    = 0;
  bit pend_valid = 1'b0;
  int pend_val   = 0;
  int blk[$];

  // Advance the model on each rising edge. The model uses the stable inputs
  // and its own state from before the edge.
  always @(posedge clk) begin
    bit take;
    int s;
    if (!rst) begin
      exp_ov     = 1'b0;
      exp_res    = 0;
      pend_valid = 1'b0;
      blk.delete();
    end else begin
      take = in_valid && !(exp_ov && !out_ready);
      if (exp_ov && out_ready) exp_ov = 1'b0;
      if (dclr) begin
        pend_valid = 1'b0;
        blk.delete();
      end else begin
        if (pend_valid) begin
          exp_ov     = 1'b1;
          exp_res    = pend_val;
          pend_valid = 1'b0;
        end
        if (take) begin
          blk.push_back(int'(din) * int'(coef));
          if (blk.size() == 8) begin
            s = 0;
            foreach (blk[i]) s += blk[i];
            pend_val   = s;
            pend_valid = 1'b1;
            blk.delete();
          end
        end
      end
    end
  end

  function automatic void check_output(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endfunction

  // Compare the DUT with the model every cycle, just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      check_output("reset_in_ready", int'(in_ready), 1);
      check_output("reset_out_valid", int'(out_valid), 0);
      check_output("reset_result", int'(result), 0);
    end else begin
      check_output("in_ready", int'(in_ready), int'(!(exp_ov && !out_ready)));
      check_output("out_valid", int'(out_valid), int'(exp_ov));
      if (exp_ov) check_output("result", int'(result), exp_res);
    end
  end

  // Drive one cycle of inputs, starting at the falling edge.
  task automatic apply_stimulus(input bit v, input int d, input int c, input bit ordy, input bit clr);
    @(negedge clk);
    in_valid  = v;
    din       = DW'(d);
    coef      = CW'(c);
    out_ready = ordy;
    dclr      = clr;
  endtask

  task automatic idle(input int n, input bit ordy);
    repeat (n) apply_stimulus(1'b0, 0, 0, ordy, 1'b0);
  endtask

  int d_tab[8] = '{17, -3, 100, -128, 127, -55, 9, 0};
  int c_tab[8] = '{-2048, 2047, -1, 513, -700, 33, 1000, -9};
  int pulses[$];

  initial begin
    // Reset is held with in_valid high. No pair may be accepted.
    repeat (3) apply_stimulus(1'b1, 5, 5, 1'b1, 1'b0);
    #2;
    check_output("hold_reset_in_ready", int'(in_ready), 1);
    check_output("hold_reset_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;

    // Block din = 1..8, coef = 1. Sum is 36, pulsed for one cycle.
    for (int i = 1; i <= 8; i++) apply_stimulus(1'b1, i, 1, 1'b1, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b1);
    #2;
    check_output("ramp_valid", int'(out_valid), 1);
    check_output("ramp_result", int'(result), 36);
    check_output("ramp_model", exp_res, 36);
    idle(1, 1'b1);
    #2;
    check_output("ramp_pulse_end", int'(out_valid), 0);

    // Largest-magnitude products: 8 * 262144 must not overflow.
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, -128, -2048, 1'b1, 1'b0);
    idle(2, 1'b1);
    #2;
    check_output("extreme_result", int'(result), 2097152);
    check_output("extreme_model", exp_res, 2097152);

    // Two blocks back to back. Results are 48 and -280, exactly 8 cycles apart.
    for (int k = 1; k <= 18; k++) begin
      if (k <= 8)       apply_stimulus(1'b1, 2, 3, 1'b1, 1'b0);
      else if (k <= 16) apply_stimulus(1'b1, -5, 7, 1'b1, 1'b0);
      else              idle(1, 1'b1);
      #2;
      if (out_valid) pulses.push_back(k);
      if (k == 10) check_output("b2b_first", int'(result), 48);
      if (k == 18) check_output("b2b_second", int'(result), -280);
    end
    check_output("b2b_pulse_count", pulses.size(), 2);
    if (pulses.size() == 2) check_output("b2b_spacing", pulses[1] - pulses[0], 8);

    // Mixed-sign products. The sum is computed by hand.
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, d_tab[i], c_tab[i], 1'b1, 1'b0);
    idle(2, 1'b1);
    #2;
    check_output("mixed_result", int'(result), -188436);
    check_output("mixed_model", exp_res, -188436);

    // Held result: input stalls and result stays fixed until taken.
    for (int i = 1; i <= 8; i++) apply_stimulus(1'b1, i, 2, 1'b0, 1'b0);
    idle(1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(1'b1, 99, 99, 1'b0, 1'b0);
      #2;
      check_output("hold_in_ready", int'(in_ready), 0);
      check_output("hold_result", int'(result), 72);
    end
    apply_stimulus(1'b0, 0, 0, 1'b1, 1'b0);
    #2;
    check_output("release_in_ready", int'(in_ready), 1);
    idle(1, 1'b1);
    #2;
    check_output("release_out_valid", int'(out_valid), 0);

    // An abort leaves a pending result alone. It discards a partial block
    // and any pair offered in the same cycle.
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 3, -4, 1'b0, 1'b0);
    idle(2, 1'b0);
    apply_stimulus(1'b0, 0, 0, 1'b0, 1'b1);
    #2;
    check_output("abort_pending_valid", int'(out_valid), 1);
    check_output("abort_pending_result", int'(result), -96);
    apply_stimulus(1'b0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 50, 50, 1'b1, 1'b0);
    apply_stimulus(1'b1, 77, 77, 1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) apply_stimulus(1'b1, i - 4, -11, 1'b1, 1'b0);
    idle(2, 1'b1);
    #2;
    check_output("abort_fresh_result", int'(result), -44);

    // Reset in the middle of a block. Outputs go to zero, and the partial
    // block is lost.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 9, 9, 1'b1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b1;
      #2;
      check_output("midreset_result", int'(result), 0);
      check_output("midreset_out_valid", int'(out_valid), 0);
    end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) apply_stimulus(1'b1, i, -1, 1'b1, 1'b0);
    idle(2, 1'b1);
    #2;
    check_output("postreset_result", int'(result), -36);
    idle(3, 1'b1);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
